// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES-128 encryption core.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } aes_fsm_e;

  localparam logic [3:0] LAST_ROUND = 4'd10;
  localparam logic [3:0] LAST_BYTE  = 4'd15;

  // Round constant for key expansion, indexed by round number 1..10.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] val;
    case (rnd)
      4'd1:    val = 8'h01;
      4'd2:    val = 8'h02;
      4'd3:    val = 8'h04;
      4'd4:    val = 8'h08;
      4'd5:    val = 8'h10;
      4'd6:    val = 8'h20;
      4'd7:    val = 8'h40;
      4'd8:    val = 8'h80;
      4'd9:    val = 8'h1b;
      4'd10:   val = 8'h36;
      default: val = 8'h00;
    endcase
    return val;
  endfunction

  // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gmul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // Byte idx of a 128-bit block; byte 0 sits in bits [127:120].
  function automatic logic [7:0] get_byte(input logic [127:0] blk, input int idx);
    return blk[127-8*idx -: 8];
  endfunction

  // Return blk with byte idx replaced by val.
  function automatic logic [127:0] put_byte(input logic [127:0] blk, input int idx,
                                            input logic [7:0] val);
    logic [127:0] res;
    res = blk;
    res[127-8*idx -: 8] = val;
    return res;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Table lookup of the forward substitution.
  always_comb begin
    out_byte = 8'h00;
    case (in_byte)
      8'h00: out_byte = 8'h63; 8'h01: out_byte = 8'h7c; 8'h02: out_byte = 8'h77; 8'h03: out_byte = 8'h7b; 8'h04: out_byte = 8'hf2; 8'h05: out_byte = 8'h6b; 8'h06: out_byte = 8'h6f; 8'h07: out_byte = 8'hc5;
      8'h08: out_byte = 8'h30; 8'h09: out_byte = 8'h01; 8'h0a: out_byte = 8'h67; 8'h0b: out_byte = 8'h2b; 8'h0c: out_byte = 8'hfe; 8'h0d: out_byte = 8'hd7; 8'h0e: out_byte = 8'hab; 8'h0f: out_byte = 8'h76;
      8'h10: out_byte = 8'hca; 8'h11: out_byte = 8'h82; 8'h12: out_byte = 8'hc9; 8'h13: out_byte = 8'h7d; 8'h14: out_byte = 8'hfa; 8'h15: out_byte = 8'h59; 8'h16: out_byte = 8'h47; 8'h17: out_byte = 8'hf0;
      8'h18: out_byte = 8'had; 8'h19: out_byte = 8'hd4; 8'h1a: out_byte = 8'ha2; 8'h1b: out_byte = 8'haf; 8'h1c: out_byte = 8'h9c; 8'h1d: out_byte = 8'ha4; 8'h1e: out_byte = 8'h72; 8'h1f: out_byte = 8'hc0;
      8'h20: out_byte = 8'hb7; 8'h21: out_byte = 8'hfd; 8'h22: out_byte = 8'h93; 8'h23: out_byte = 8'h26; 8'h24: out_byte = 8'h36; 8'h25: out_byte = 8'h3f; 8'h26: out_byte = 8'hf7; 8'h27: out_byte = 8'hcc;
      8'h28: out_byte = 8'h34; 8'h29: out_byte = 8'ha5; 8'h2a: out_byte = 8'he5; 8'h2b: out_byte = 8'hf1; 8'h2c: out_byte = 8'h71; 8'h2d: out_byte = 8'hd8; 8'h2e: out_byte = 8'h31; 8'h2f: out_byte = 8'h15;
      8'h30: out_byte = 8'h04; 8'h31: out_byte = 8'hc7; 8'h32: out_byte = 8'h23; 8'h33: out_byte = 8'hc3; 8'h34: out_byte = 8'h18; 8'h35: out_byte = 8'h96; 8'h36: out_byte = 8'h05; 8'h37: out_byte = 8'h9a;
      8'h38: out_byte = 8'h07; 8'h39: out_byte = 8'h12; 8'h3a: out_byte = 8'h80; 8'h3b: out_byte = 8'he2; 8'h3c: out_byte = 8'heb; 8'h3d: out_byte = 8'h27; 8'h3e: out_byte = 8'hb2; 8'h3f: out_byte = 8'h75;
      8'h40: out_byte = 8'h09; 8'h41: out_byte = 8'h83; 8'h42: out_byte = 8'h2c; 8'h43: out_byte = 8'h1a; 8'h44: out_byte = 8'h1b; 8'h45: out_byte = 8'h6e; 8'h46: out_byte = 8'h5a; 8'h47: out_byte = 8'ha0;
      8'h48: out_byte = 8'h52; 8'h49: out_byte = 8'h3b; 8'h4a: out_byte = 8'hd6; 8'h4b: out_byte = 8'hb3; 8'h4c: out_byte = 8'h29; 8'h4d: out_byte = 8'he3; 8'h4e: out_byte = 8'h2f; 8'h4f: out_byte = 8'h84;
      8'h50: out_byte = 8'h53; 8'h51: out_byte = 8'hd1; 8'h52: out_byte = 8'h00; 8'h53: out_byte = 8'hed; 8'h54: out_byte = 8'h20; 8'h55: out_byte = 8'hfc; 8'h56: out_byte = 8'hb1; 8'h57: out_byte = 8'h5b;
      8'h58: out_byte = 8'h6a; 8'h59: out_byte = 8'hcb; 8'h5a: out_byte = 8'hbe; 8'h5b: out_byte = 8'h39; 8'h5c: out_byte = 8'h4a; 8'h5d: out_byte = 8'h4c; 8'h5e: out_byte = 8'h58; 8'h5f: out_byte = 8'hcf;
      8'h60: out_byte = 8'hd0; 8'h61: out_byte = 8'hef; 8'h62: out_byte = 8'haa; 8'h63: out_byte = 8'hfb; 8'h64: out_byte = 8'h43; 8'h65: out_byte = 8'h4d; 8'h66: out_byte = 8'h33; 8'h67: out_byte = 8'h85;
      8'h68: out_byte = 8'h45; 8'h69: out_byte = 8'hf9; 8'h6a: out_byte = 8'h02; 8'h6b: out_byte = 8'h7f; 8'h6c: out_byte = 8'h50; 8'h6d: out_byte = 8'h3c; 8'h6e: out_byte = 8'h9f; 8'h6f: out_byte = 8'ha8;
      8'h70: out_byte = 8'h51; 8'h71: out_byte = 8'ha3; 8'h72: out_byte = 8'h40; 8'h73: out_byte = 8'h8f; 8'h74: out_byte = 8'h92; 8'h75: out_byte = 8'h9d; 8'h76: out_byte = 8'h38; 8'h77: out_byte = 8'hf5;
      8'h78: out_byte = 8'hbc; 8'h79: out_byte = 8'hb6; 8'h7a: out_byte = 8'hda; 8'h7b: out_byte = 8'h21; 8'h7c: out_byte = 8'h10; 8'h7d: out_byte = 8'hff; 8'h7e: out_byte = 8'hf3; 8'h7f: out_byte = 8'hd2;
      8'h80: out_byte = 8'hcd; 8'h81: out_byte = 8'h0c; 8'h82: out_byte = 8'h13; 8'h83: out_byte = 8'hec; 8'h84: out_byte = 8'h5f; 8'h85: out_byte = 8'h97; 8'h86: out_byte = 8'h44; 8'h87: out_byte = 8'h17;
      8'h88: out_byte = 8'hc4; 8'h89: out_byte = 8'ha7; 8'h8a: out_byte = 8'h7e; 8'h8b: out_byte = 8'h3d; 8'h8c: out_byte = 8'h64; 8'h8d: out_byte = 8'h5d; 8'h8e: out_byte = 8'h19; 8'h8f: out_byte = 8'h73;
      8'h90: out_byte = 8'h60; 8'h91: out_byte = 8'h81; 8'h92: out_byte = 8'h4f; 8'h93: out_byte = 8'hdc; 8'h94: out_byte = 8'h22; 8'h95: out_byte = 8'h2a; 8'h96: out_byte = 8'h90; 8'h97: out_byte = 8'h88;
      8'h98: out_byte = 8'h46; 8'h99: out_byte = 8'hee; 8'h9a: out_byte = 8'hb8; 8'h9b: out_byte = 8'h14; 8'h9c: out_byte = 8'hde; 8'h9d: out_byte = 8'h5e; 8'h9e: out_byte = 8'h0b; 8'h9f: out_byte = 8'hdb;
      8'ha0: out_byte = 8'he0; 8'ha1: out_byte = 8'h32; 8'ha2: out_byte = 8'h3a; 8'ha3: out_byte = 8'h0a; 8'ha4: out_byte = 8'h49; 8'ha5: out_byte = 8'h06; 8'ha6: out_byte = 8'h24; 8'ha7: out_byte = 8'h5c;
      8'ha8: out_byte = 8'hc2; 8'ha9: out_byte = 8'hd3; 8'haa: out_byte = 8'hac; 8'hab: out_byte = 8'h62; 8'hac: out_byte = 8'h91; 8'had: out_byte = 8'h95; 8'hae: out_byte = 8'he4; 8'haf: out_byte = 8'h79;
      8'hb0: out_byte = 8'he7; 8'hb1: out_byte = 8'hc8; 8'hb2: out_byte = 8'h37; 8'hb3: out_byte = 8'h6d; 8'hb4: out_byte = 8'h8d; 8'hb5: out_byte = 8'hd5; 8'hb6: out_byte = 8'h4e; 8'hb7: out_byte = 8'ha9;
      8'hb8: out_byte = 8'h6c; 8'hb9: out_byte = 8'h56; 8'hba: out_byte = 8'hf4; 8'hbb: out_byte = 8'hea; 8'hbc: out_byte = 8'h65; 8'hbd: out_byte = 8'h7a; 8'hbe: out_byte = 8'hae; 8'hbf: out_byte = 8'h08;
      8'hc0: out_byte = 8'hba; 8'hc1: out_byte = 8'h78; 8'hc2: out_byte = 8'h25; 8'hc3: out_byte = 8'h2e; 8'hc4: out_byte = 8'h1c; 8'hc5: out_byte = 8'ha6; 8'hc6: out_byte = 8'hb4; 8'hc7: out_byte = 8'hc6;
      8'hc8: out_byte = 8'he8; 8'hc9: out_byte = 8'hdd; 8'hca: out_byte = 8'h74; 8'hcb: out_byte = 8'h1f; 8'hcc: out_byte = 8'h4b; 8'hcd: out_byte = 8'hbd; 8'hce: out_byte = 8'h8b; 8'hcf: out_byte = 8'h8a;
      8'hd0: out_byte = 8'h70; 8'hd1: out_byte = 8'h3e; 8'hd2: out_byte = 8'hb5; 8'hd3: out_byte = 8'h66; 8'hd4: out_byte = 8'h48; 8'hd5: out_byte = 8'h03; 8'hd6: out_byte = 8'hf6; 8'hd7: out_byte = 8'h0e;
      8'hd8: out_byte = 8'h61; 8'hd9: out_byte = 8'h35; 8'hda: out_byte = 8'h57; 8'hdb: out_byte = 8'hb9; 8'hdc: out_byte = 8'h86; 8'hdd: out_byte = 8'hc1; 8'hde: out_byte = 8'h1d; 8'hdf: out_byte = 8'h9e;
      8'he0: out_byte = 8'he1; 8'he1: out_byte = 8'hf8; 8'he2: out_byte = 8'h98; 8'he3: out_byte = 8'h11; 8'he4: out_byte = 8'h69; 8'he5: out_byte = 8'hd9; 8'he6: out_byte = 8'h8e; 8'he7: out_byte = 8'h94;
      8'he8: out_byte = 8'h9b; 8'he9: out_byte = 8'h1e; 8'hea: out_byte = 8'h87; 8'heb: out_byte = 8'he9; 8'hec: out_byte = 8'hce; 8'hed: out_byte = 8'h55; 8'hee: out_byte = 8'h28; 8'hef: out_byte = 8'hdf;
      8'hf0: out_byte = 8'h8c; 8'hf1: out_byte = 8'ha1; 8'hf2: out_byte = 8'h89; 8'hf3: out_byte = 8'h0d; 8'hf4: out_byte = 8'hbf; 8'hf5: out_byte = 8'he6; 8'hf6: out_byte = 8'h42; 8'hf7: out_byte = 8'h68;
      8'hf8: out_byte = 8'h41; 8'hf9: out_byte = 8'h99; 8'hfa: out_byte = 8'h2d; 8'hfb: out_byte = 8'h0f; 8'hfc: out_byte = 8'hb0; 8'hfd: out_byte = 8'h54; 8'hfe: out_byte = 8'hbb; 8'hff: out_byte = 8'h16;
      default: out_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/aes128_encrypt.sv
// Iterative AES-128 encryptor: one round per clock, forward key expansion,
// ciphertext streamed MSB byte first on an 8-bit registered port. Free-running:
// after the last byte it re-samples data_in/key and starts the next block.
module aes128_encrypt
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic [7:0]   data_out,
  output logic         out_valid
);

  aes_fsm_e     fsm_q, fsm_d;
  logic [3:0]   cnt_q, cnt_d;        // round number in ROUND, byte index in OUT
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [7:0]   data_out_q, data_out_d;
  logic         out_valid_q, out_valid_d;

  logic [7:0]   st_byte [16];
  logic [7:0]   sb      [16];
  logic [7:0]   sr      [16];
  logic [7:0]   mc      [16];
  logic [7:0]   sw_in   [4];
  logic [7:0]   sw_out  [4];
  logic [31:0]  kw_temp, kw0, kw1, kw2, kw3;
  logic [127:0] rk_next;
  logic [127:0] round_val;
  logic         last_round;

  assign last_round = (cnt_q == LAST_ROUND);

  // SubBytes: one S-box per state byte.
  for (genvar g = 0; g < 16; g++) begin : g_sub
    assign st_byte[g] = get_byte(state_q, g);
    aes_sbox u_sbox (
      .in_byte  (st_byte[g]),
      .out_byte (sb[g])
    );
  end

  // SubWord of RotWord(w3) for the key schedule.
  for (genvar g = 0; g < 4; g++) begin : g_subword
    assign sw_in[g] = rk_q[23-8*g+32*(g==3 ? 1 : 0) -: 8];
    aes_sbox u_sbox (
      .in_byte  (sw_in[g]),
      .out_byte (sw_out[g])
    );
  end

  // Next round key from the current one (round number selects Rcon).
  always_comb begin
    kw_temp = {sw_out[0] ^ rcon(cnt_q), sw_out[1], sw_out[2], sw_out[3]};
    kw0     = rk_q[127:96] ^ kw_temp;
    kw1     = rk_q[95:64]  ^ kw0;
    kw2     = rk_q[63:32]  ^ kw1;
    kw3     = rk_q[31:0]   ^ kw2;
    rk_next = {kw0, kw1, kw2, kw3};
  end

  // ShiftRows: byte 4c+r is column c, row r; row r rotates left by r columns.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
  end

  // MixColumns on each column of the shifted state.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = gmul2(sr[4*c]) ^ gmul3(sr[4*c+1]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ gmul2(sr[4*c+1]) ^ gmul3(sr[4*c+2]) ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ gmul2(sr[4*c+2]) ^ gmul3(sr[4*c+3]);
      mc[4*c+3] = gmul3(sr[4*c]) ^ sr[4*c+1] ^ sr[4*c+2] ^ gmul2(sr[4*c+3]);
    end
  end

  // AddRoundKey; the final round skips MixColumns.
  always_comb begin
    round_val = '0;
    for (int i = 0; i < 16; i++) begin
      round_val = put_byte(round_val, i,
                           (last_round ? sr[i] : mc[i]) ^ get_byte(rk_next, i));
    end
  end

  // FSM state and all datapath registers; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= ST_IDLE;
      cnt_q       <= 4'd0;
      state_q     <= '0;
      rk_q        <= '0;
      data_out_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      rk_q        <= rk_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic: IDLE -> LOAD -> ROUND 1..10 -> OUT 0..15 -> LOAD.
  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    case (fsm_q)
      ST_IDLE: begin
        fsm_d = ST_LOAD;
      end
      ST_LOAD: begin
        fsm_d = ST_ROUND;
        cnt_d = 4'd1;
      end
      ST_ROUND: begin
        if (last_round) begin
          fsm_d = ST_OUT;
          cnt_d = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_OUT: begin
        if (cnt_q == LAST_BYTE) begin
          fsm_d = ST_LOAD;
          cnt_d = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        fsm_d = ST_IDLE;
        cnt_d = 4'd0;
      end
    endcase
  end

  // Datapath updates: sample inputs at LOAD, apply one round per ROUND cycle.
  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    case (fsm_q)
      ST_LOAD: begin
        state_d = data_in ^ key;
        rk_d    = key;
      end
      ST_ROUND: begin
        state_d = round_val;
        rk_d    = rk_next;
      end
      default: begin
        state_d = state_q;
        rk_d    = rk_q;
      end
    endcase
  end

  // Output mux: stream ciphertext bytes in OUT, otherwise hold the last byte.
  always_comb begin
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    if (fsm_q == ST_OUT) begin
      data_out_d  = st_byte[cnt_q];
      out_valid_d = 1'b1;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_aes128_encrypt.sv
// Self-checking bench for aes128_encrypt: known-answer vectors, output window
// timing, block period, input isolation and mid-stream reset.
module tb_aes128_encrypt;

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic [127:0] data_in;
  logic [127:0] key;
  logic [7:0]   data_out;
  logic         out_valid;

  int           n_cmp;
  int           n_bad;
  int           edge_no;
  logic [7:0]   exp_q [$];
  logic [7:0]   exp_hold;
  vec_t         vecs [3];

  aes128_encrypt dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .key       (key),
    .data_out  (data_out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (edge %0d): got %0h, want %0h", name, edge_no, act, exp);
    end
  endtask

  function automatic logic exp_valid(input int e);
    return (e >= 13) && (((e - 13) % 27) < 16);
  endfunction

  task automatic push_block(input logic [127:0] ct);
    for (int b = 0; b < 16; b++) exp_q.push_back(ct[127-8*b -: 8]);
  endtask

  // Advance n rising edges, checking out_valid and data_out after each one.
  task automatic watch(input int n);
    logic ev;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      edge_no++;
      @(negedge clk);
      ev = exp_valid(edge_no);
      check("out_valid", {127'd0, out_valid}, {127'd0, ev});
      if (ev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard_empty (edge %0d): got byte %0h, want none", edge_no, data_out);
        end else begin
          exp_hold = exp_q.pop_front();
          check("data_out", {120'd0, data_out}, {120'd0, exp_hold});
        end
      end else begin
        check("data_out_hold", {120'd0, data_out}, {120'd0, exp_hold});
      end
    end
  endtask

  // Assert reset at a falling edge and check outputs while it is held.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    exp_hold = 8'h00;
    @(negedge clk);
    check("rst_data_out", {120'd0, data_out}, 128'd0);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
  endtask

  task automatic release_reset();
    rst_n   = 1'b1;
    edge_no = 0;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    edge_no  = 0;
    exp_hold = 8'h00;
    data_in  = '0;
    key      = '0;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;

    vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                pt:  128'h3243f6a8885a308d313198a2e0370734,
                ct:  128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                pt:  128'h00112233445566778899aabbccddeeff,
                ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{key: 128'h0,
                pt:  128'h0,
                ct:  128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    // Known-answer vectors, one block each from reset.
    for (int v = 0; v < 3; v++) begin
      do_reset();
      data_in = vecs[v].pt;
      key     = vecs[v].key;
      push_block(vecs[v].ct);
      release_reset();
      watch(30);
      check("drained", exp_q.size(), 128'd0);
    end

    // Inputs change right after the LOAD edge: current block unaffected,
    // next block (27 cycles later) uses the new inputs.
    do_reset();
    data_in = vecs[0].pt;
    key     = vecs[0].key;
    push_block(vecs[0].ct);
    release_reset();
    watch(2);
    data_in = vecs[1].pt;
    key     = vecs[1].key;
    push_block(vecs[1].ct);
    watch(54);
    check("drained_iso", exp_q.size(), 128'd0);

    // Reset while byte 5 is on the port, then a clean restart.
    do_reset();
    data_in = vecs[0].pt;
    key     = vecs[0].key;
    push_block(vecs[0].ct);
    release_reset();
    watch(18);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_data_out", {120'd0, data_out}, 128'd0);
    check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    exp_q.delete();
    exp_hold = 8'h00;
    @(negedge clk);
    push_block(vecs[0].ct);
    release_reset();
    watch(30);
    check("drained_rst", exp_q.size(), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
